// File: rtl/uart_mem_dump_pkg.sv
// rtl/uart_mem_dump_pkg.sv - shared UART frame constants and dump FSM encodings
// Purpose: constants and types shared by the memory-dump top and its serializer.
//   DATA_BITS / FRAME_BITS describe an 8N1 frame (start, 8 data, stop).
//   dump_state_t encodes the dump FSM; word_byte() picks a little-endian byte.
// Ports: none (package).
package uart_mem_dump_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_FINISH
  } dump_state_t;

  // Byte idx of a 32-bit word, little-endian (idx 0 = bits [7:0]).
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_mem_dump_tx_byte.sv
// rtl/uart_mem_dump_tx_byte.sv - 8N1 UART byte serializer with valid/ready input
// Purpose: shifts one byte out as start(0), d0..d7, stop(1), each bit CLKS_PER_BIT
//   cycles. A byte accepted in cycle t drives the start bit from t+1; ready_o
//   returns high in the cycle after the last stop-bit cycle.
// Ports:
//   board_clk  in   clock, rising edge
//   board_rst  in   synchronous active-high reset
//   byte_i     in   byte to send, taken when valid_i & ready_o
//   valid_i    in   byte_i is valid
//   ready_o    out  serializer idle, can accept a byte
//   tx_o       out  serial line, idle high
module uart_tx_byte
  import uart_mem_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       board_clk,
  input  logic       board_rst,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

  logic              r_busy;
  logic [CW-1:0]     r_cnt;
  logic [3:0]        r_idx;
  logic [DATA_BITS:0] r_shift;   // remaining bits after the one on the line: data then stop
  logic              r_tx;

  always_ff @(posedge board_clk) begin
    if (board_rst) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '1;
      r_tx    <= 1'b1;
    end else if (!r_busy) begin
      if (valid_i) begin
        r_busy  <= 1'b1;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_shift <= {1'b1, byte_i};
        r_tx    <= 1'b0;
      end
    end else if (r_cnt == LAST_CNT) begin
      r_cnt <= '0;
      if (r_idx == LAST_BIT) begin
        r_busy <= 1'b0;
        r_tx   <= 1'b1;
      end else begin
        r_idx   <= r_idx + 4'd1;
        r_tx    <= r_shift[0];
        r_shift <= {1'b1, r_shift[DATA_BITS:1]};
      end
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign ready_o = ~r_busy;
  assign tx_o    = r_tx;

endmodule

// File: rtl/uart_mem_dump.sv
// rtl/uart_mem_dump.sv - dumps a range of 32-bit BRAM words over UART 8N1
// Purpose: on start, reads word_cnt_i words from base_adr_i upward (address wraps)
//   and sends each word little-endian as four UART bytes; pulses done_o once the
//   last stop bit has completed.
// Ports:
//   board_clk   in   clock, rising edge
//   board_rst   in   synchronous active-high reset
//   start_i     in   start request, sampled only in IDLE
//   base_adr_i  in   first word address, latched on accepted start
//   word_cnt_i  in   words to send, latched on accepted start (0 = none)
//   mem_rd_o    out  memory read strobe, one cycle per word
//   mem_adr_o   out  memory word address, holds outside a read
//   mem_dat_i   in   read data, valid one cycle after mem_rd_o
//   upg_tx_o    out  UART serial output, idle high
//   busy_o      out  transfer in progress
//   done_o      out  one-cycle completion pulse
module uart_mem_dump
  import uart_mem_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADR_W        = 15,
  parameter int CNT_W        = 16
) (
  input  logic             board_clk,
  input  logic             board_rst,
  input  logic             start_i,
  input  logic [ADR_W-1:0] base_adr_i,
  input  logic [CNT_W-1:0] word_cnt_i,
  output logic             mem_rd_o,
  output logic [ADR_W-1:0] mem_adr_o,
  input  logic [31:0]      mem_dat_i,
  output logic             upg_tx_o,
  output logic             busy_o,
  output logic             done_o
);

  dump_state_t      r_state, w_next;
  logic [ADR_W-1:0] r_adr;       // address of the word being fetched/sent
  logic [ADR_W-1:0] r_last_adr;  // last address presented, held between reads
  logic [CNT_W-1:0] r_remain;
  logic [31:0]      r_hold;
  logic [1:0]       r_byte_idx;
  logic             r_busy;
  logic             r_done;

  logic             w_tx_valid;
  logic             w_tx_ready;
  logic             w_fire;
  logic [7:0]       w_byte;

  always_ff @(posedge board_clk) begin
    if (board_rst) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_tx_valid = 1'b0;
    case (r_state)
      S_IDLE:   if (start_i) w_next = (word_cnt_i == '0) ? S_FINISH : S_FETCH;
      S_FETCH:  w_next = S_WAIT;
      S_WAIT:   w_next = S_SEND;
      S_SEND: begin
        w_tx_valid = 1'b1;
        if (w_tx_ready && r_byte_idx == 2'd3)
          w_next = (r_remain == CNT_W'(1)) ? S_FINISH : S_FETCH;
      end
      S_FINISH: if (w_tx_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_fire = w_tx_valid & w_tx_ready;
  assign w_byte = word_byte(r_hold, r_byte_idx);

  always_ff @(posedge board_clk) begin
    if (board_rst) begin
      r_adr      <= '0;
      r_last_adr <= '0;
      r_remain   <= '0;
      r_hold     <= '0;
      r_byte_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_adr      <= base_adr_i;
            r_remain   <= word_cnt_i;
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
          end
        end
        S_FETCH: r_last_adr <= r_adr;
        S_WAIT: begin
          r_hold     <= mem_dat_i;
          r_byte_idx <= '0;
        end
        S_SEND: begin
          if (w_fire) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_adr    <= r_adr + ADR_W'(1);
              r_remain <= r_remain - CNT_W'(1);
            end
          end
        end
        S_FINISH: begin
          // Serializer idle means the final stop bit has fully elapsed.
          if (w_tx_ready) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_rd_o  = (r_state == S_FETCH);
  assign mem_adr_o = (r_state == S_FETCH) ? r_adr : r_last_adr;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .board_clk(board_clk),
    .board_rst(board_rst),
    .byte_i   (w_byte),
    .valid_i  (w_tx_valid),
    .ready_o  (w_tx_ready),
    .tx_o     (upg_tx_o)
  );

endmodule

// File: tb/tb_uart_mem_dump.sv
// tb/tb_uart_mem_dump.sv - self-checking bench for uart_mem_dump
module tb_uart_mem_dump;

  localparam int CPB   = 4;
  localparam int ADR_W = 15;
  localparam int CNT_W = 16;
  localparam int FRAME = 10 * CPB;

  logic             board_clk = 1'b0;
  logic             board_rst = 1'b1;
  logic             start_i = 1'b0;
  logic [ADR_W-1:0] base_adr_i = '0;
  logic [CNT_W-1:0] word_cnt_i = '0;
  logic             mem_rd_o;
  logic [ADR_W-1:0] mem_adr_o;
  logic [31:0]      mem_dat_i = '0;
  logic             upg_tx_o;
  logic             busy_o;
  logic             done_o;

  uart_mem_dump #(.CLKS_PER_BIT(CPB), .ADR_W(ADR_W), .CNT_W(CNT_W)) dut (
    .board_clk (board_clk),
    .board_rst (board_rst),
    .start_i   (start_i),
    .base_adr_i(base_adr_i),
    .word_cnt_i(word_cnt_i),
    .mem_rd_o  (mem_rd_o),
    .mem_adr_o (mem_adr_o),
    .mem_dat_i (mem_dat_i),
    .upg_tx_o  (upg_tx_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 board_clk = ~board_clk;

  logic [31:0] mem [0:(1<<ADR_W)-1];
  always @(posedge board_clk) if (mem_rd_o) mem_dat_i <= mem[mem_adr_o];

  int cyc = 0;
  always @(posedge board_clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
    logic       stop_ok;
  } frame_t;

  frame_t           rx_q[$];
  logic [7:0]       exp_q[$];
  logic [ADR_W-1:0] exp_adr_q[$];
  logic [ADR_W-1:0] rd_q[$];
  int mon_starts = 0;
  int done_cnt   = 0;
  int done_cyc   = 0;
  int last_start = 0;
  int cmp_n = 0;
  int err_n = 0;

  always @(negedge board_clk) begin
    if (!board_rst && mem_rd_o) rd_q.push_back(mem_adr_o);
    if (done_o) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // UART monitor: samples each bit near its centre.
  initial begin : uart_mon
    frame_t     f;
    logic [7:0] d;
    logic       start_ok;
    forever begin
      @(negedge board_clk);
      if (!board_rst && upg_tx_o === 1'b0) begin
        f.start    = cyc;
        mon_starts = mon_starts + 1;
        repeat (CPB / 2) @(negedge board_clk);
        start_ok = (upg_tx_o === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge board_clk);
          d[i] = upg_tx_o;
        end
        repeat (CPB) @(negedge board_clk);
        f.stop_ok = (upg_tx_o === 1'b1) && start_ok;
        f.data    = d;
        rx_q.push_back(f);
        repeat (CPB / 2 - 1) @(negedge board_clk);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic kick(input logic [ADR_W-1:0] base, input logic [CNT_W-1:0] cnt, input bit expect_it);
    logic [ADR_W-1:0] a;
    logic [31:0]      w;
    @(negedge board_clk);
    start_i    = 1'b1;
    base_adr_i = base;
    word_cnt_i = cnt;
    if (expect_it) begin
      for (int k = 0; k < int'(cnt); k++) begin
        a = base + ADR_W'(k);
        w = mem[a];
        exp_adr_q.push_back(a);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
      end
    end
    @(negedge board_clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge board_clk);
      n++;
    end
    cmp_n++;
    if (done_cnt == d0) begin
      err_n++;
      $display("FAIL %s done_timeout: done pulses %0d, required 1 within %0d cycles", name, done_cnt - d0, budget);
    end
    repeat (4) @(negedge board_clk);
  endtask

  // Pops the scoreboard: bytes, framing, inter-frame gaps and read addresses.
  task automatic score(input string name);
    frame_t           f;
    logic [7:0]       e;
    logic [ADR_W-1:0] ea, ra;
    int i = 0;
    int prev = 0;
    int gap, lim;
    cmp_n++;
    if (rx_q.size() != exp_q.size()) begin
      err_n++;
      $display("FAIL %s byte_count: got %0d, required %0d", name, rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      f = rx_q.pop_front();
      e = exp_q.pop_front();
      cmp_n++;
      if (f.data !== e) begin
        err_n++;
        $display("FAIL %s byte[%0d]: got 0x%02h, required 0x%02h", name, i, f.data, e);
      end
      cmp_n++;
      if (f.stop_ok !== 1'b1) begin
        err_n++;
        $display("FAIL %s framing[%0d]: start/stop level wrong, got %b, required 1", name, i, f.stop_ok);
      end
      if (i > 0) begin
        gap = f.start - prev - FRAME;
        lim = (i % 4 == 0) ? 4 : 1;
        cmp_n++;
        if (gap < 0 || gap > lim) begin
          err_n++;
          $display("FAIL %s gap[%0d]: got %0d idle cycles, required 0..%0d", name, i, gap, lim);
        end
      end
      prev       = f.start;
      last_start = f.start;
      i++;
    end
    cmp_n++;
    if (rd_q.size() != exp_adr_q.size()) begin
      err_n++;
      $display("FAIL %s read_count: got %0d, required %0d", name, rd_q.size(), exp_adr_q.size());
    end
    while (rd_q.size() > 0 && exp_adr_q.size() > 0) begin
      ra = rd_q.pop_front();
      ea = exp_adr_q.pop_front();
      cmp_n++;
      if (ra !== ea) begin
        err_n++;
        $display("FAIL %s read_adr: got 0x%04h, required 0x%04h", name, ra, ea);
      end
    end
    rx_q.delete();
    exp_q.delete();
    rd_q.delete();
    exp_adr_q.delete();
  endtask

  task automatic test_reset;
    board_rst = 1'b1;
    repeat (3) @(negedge board_clk);
    cmp_n++; if (upg_tx_o !== 1'b1) begin err_n++; $display("FAIL reset tx: got %b, required 1", upg_tx_o); end
    cmp_n++; if (mem_rd_o !== 1'b0) begin err_n++; $display("FAIL reset mem_rd: got %b, required 0", mem_rd_o); end
    cmp_n++; if (mem_adr_o !== '0) begin err_n++; $display("FAIL reset mem_adr: got 0x%04h, required 0", mem_adr_o); end
    cmp_n++; if (busy_o !== 1'b0) begin err_n++; $display("FAIL reset busy: got %b, required 0", busy_o); end
    cmp_n++; if (done_o !== 1'b0) begin err_n++; $display("FAIL reset done: got %b, required 0", done_o); end
    board_rst = 1'b0;
    repeat (2) @(negedge board_clk);
  endtask

  task automatic test_single_word;
    int d0;
    mem[15'h0010] = 32'h44332211;
    d0 = done_cnt;
    kick(15'h0010, 16'd1, 1'b1);
    wait_done("single", d0, 400);
    score("single");
    repeat (10) @(negedge board_clk);
    cmp_n++;
    if (done_cnt - d0 != 1) begin
      err_n++;
      $display("FAIL single done_pulses: got %0d, required 1", done_cnt - d0);
    end
    cmp_n++;
    if (done_cyc - last_start < FRAME || done_cyc - last_start > FRAME + 1) begin
      err_n++;
      $display("FAIL single done_timing: got %0d cycles after last start bit, required %0d..%0d", done_cyc - last_start, FRAME, FRAME + 1);
    end
    cmp_n++;
    if (busy_o !== 1'b0) begin err_n++; $display("FAIL single busy_after: got %b, required 0", busy_o); end
  endtask

  task automatic test_wrap;
    int d0;
    mem[15'h7FFF] = $urandom;
    mem[15'h0000] = $urandom;
    d0 = done_cnt;
    kick(15'h7FFF, 16'd2, 1'b1);
    wait_done("wrap", d0, 800);
    score("wrap");
  endtask

  task automatic test_zero_count;
    int d0, s0, bc, lows;
    d0 = done_cnt;
    s0 = mon_starts;
    bc = 0;
    lows = 0;
    kick(15'h0123, 16'd0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (busy_o === 1'b1) bc++;
      if (upg_tx_o !== 1'b1) lows++;
      @(negedge board_clk);
    end
    cmp_n++; if (bc != 1) begin err_n++; $display("FAIL zero busy_cycles: got %0d, required 1", bc); end
    cmp_n++; if (done_cnt - d0 != 1) begin err_n++; $display("FAIL zero done_pulses: got %0d, required 1", done_cnt - d0); end
    cmp_n++; if (lows != 0 || mon_starts != s0) begin err_n++; $display("FAIL zero tx_idle: got %0d low cycles, required 0", lows); end
    cmp_n++; if (rd_q.size() != 0) begin err_n++; $display("FAIL zero mem_rd: got %0d reads, required 0", rd_q.size()); end
    rd_q.delete();
  endtask

  task automatic test_restart_ignored;
    int d0;
    mem[15'h0100] = 32'hA1B2C3D4;
    mem[15'h0101] = 32'h0F1E2D3C;
    mem[15'h0200] = 32'hDEADBEEF;
    d0 = done_cnt;
    kick(15'h0100, 16'd2, 1'b1);
    repeat (60) @(negedge board_clk);
    kick(15'h0200, 16'd1, 1'b0);
    wait_done("restart", d0, 800);
    score("restart");
    repeat (10) @(negedge board_clk);
    cmp_n++;
    if (done_cnt - d0 != 1) begin
      err_n++;
      $display("FAIL restart done_pulses: got %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_transfer;
    int d0, s0, n;
    mem[15'h0300] = 32'h8C5A3E71;
    d0 = done_cnt;
    s0 = mon_starts;
    n = 0;
    kick(15'h0300, 16'd1, 1'b1);
    while (mon_starts < s0 + 3 && n < 500) begin
      @(negedge board_clk);
      n++;
    end
    cmp_n++;
    if (mon_starts < s0 + 3) begin
      err_n++;
      $display("FAIL rstmid third_byte: got %0d frames, required 3", mon_starts - s0);
    end
    repeat (8) @(negedge board_clk);
    board_rst = 1'b1;
    @(negedge board_clk);
    cmp_n++; if (upg_tx_o !== 1'b1) begin err_n++; $display("FAIL rstmid tx: got %b, required 1", upg_tx_o); end
    cmp_n++; if (busy_o !== 1'b0) begin err_n++; $display("FAIL rstmid busy: got %b, required 0", busy_o); end
    board_rst = 1'b0;
    repeat (60) @(negedge board_clk);
    cmp_n++; if (done_cnt != d0) begin err_n++; $display("FAIL rstmid done: got %0d pulses, required 0", done_cnt - d0); end
    rx_q.delete();
    exp_q.delete();
    rd_q.delete();
    exp_adr_q.delete();
    kick(15'h0300, 16'd1, 1'b1);
    wait_done("rstmid_rerun", d0, 400);
    score("rstmid_rerun");
  endtask

  task automatic test_back_to_back;
    int d0;
    for (int k = 0; k < 3; k++) mem[15'h0400 + 15'(k)] = $urandom;
    d0 = done_cnt;
    kick(15'h0400, 16'd3, 1'b1);
    wait_done("b2b", d0, 1200);
    score("b2b");
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_wrap;
    test_zero_count;
    test_restart_ignored;
    test_reset_mid_transfer;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
